// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg -- shared definitions for the multiplexed seven-segment driver.
//   scan_state_t : scan FSM states (BLANK = inter-digit dark cycle, SHOW = lit)
//   SEG_BLANK    : active-low segment pattern with every segment off
//   hex_to_seg() : 4-bit hex nibble -> active-low {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
package seg_pkg;

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } scan_state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] seg_val;
      case (nib)
         4'h0:    seg_val = 7'h40;
         4'h1:    seg_val = 7'h79;
         4'h2:    seg_val = 7'h24;
         4'h3:    seg_val = 7'h30;
         4'h4:    seg_val = 7'h19;
         4'h5:    seg_val = 7'h12;
         4'h6:    seg_val = 7'h02;
         4'h7:    seg_val = 7'h78;
         4'h8:    seg_val = 7'h00;
         4'h9:    seg_val = 7'h10;
         4'hA:    seg_val = 7'h08;
         4'hB:    seg_val = 7'h03;
         4'hC:    seg_val = 7'h46;
         4'hD:    seg_val = 7'h21;
         4'hE:    seg_val = 7'h06;
         default: seg_val = 7'h0E;
      endcase
      return seg_val;
   endfunction

endpackage

// File: rtl/seg_scan_driver_tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen -- enabled prescaler producing a one-cycle tick every DIV enabled
// cycles. The count only advances while en is high, so a slot that starts
// with the counter at 0 lasts exactly DIV cycles.
//   clk     : system clock
//   reset_n : asynchronous active-low reset (clears the count)
//   en      : count enable
//   tick    : high for the enabled cycle in which count = DIV-1
// ---------------------------------------------------------------------------
module tick_gen #(
   parameter int DIV = 48000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   output logic tick
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

   generate
      if (DIV < 2) begin : g_bad_div
         $error("tick_gen: DIV must be >= 2");
      end
   endgenerate

   logic [CNT_W-1:0] count_reg;

   assign tick = en && (count_reg == CNT_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_reg <= '0;
      end else if (en) begin
         count_reg <= tick ? '0 : count_reg + CNT_W'(1);
      end
   end

endmodule

// File: rtl/seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seg_scan_driver -- time-multiplexed hex display driver for common-anode
// seven-segment digits with break-before-make blanking, tear-free updates
// and a frame-based blink.
//   clk        : system clock
//   reset_n    : asynchronous active-low reset (outputs go dark at once)
//   load       : capture digits_in (applied at the next frame boundary)
//   digits_in  : hex nibbles, digit i = bits [4i+3:4i]
//   blank_mask : bit i high keeps digit i dark
//   blink_en   : gate the whole display with the blink phase
//   seg        : active-low segments {g,f,e,d,c,b,a}, registered
//   an         : active-low digit enables, at most one low, registered
//   frame_done : one-cycle pulse when the last digit slot ends
// ---------------------------------------------------------------------------
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 48000,
   parameter int BLINK_FRAMES = 128
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   blank_mask,
   input  logic                    blink_en,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLINK_FRAMES - 1);

   generate
      if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
         $error("seg_scan_driver: NUM_DIGITS must be 1..8");
      end
      if (REFRESH_DIV < 2) begin : g_bad_div
         $error("seg_scan_driver: REFRESH_DIV must be >= 2");
      end
      if (BLINK_FRAMES < 1) begin : g_bad_blink
         $error("seg_scan_driver: BLINK_FRAMES must be >= 1");
      end
   endgenerate

   scan_state_t             state_reg;
   logic [IDX_W-1:0]        idx_reg;
   logic [FC_W-1:0]         frame_cnt_reg;
   logic                    blink_phase_reg;
   logic                    pending_reg;
   logic [4*NUM_DIGITS-1:0] shadow_reg;
   logic [4*NUM_DIGITS-1:0] display_reg;
   logic [6:0]              seg_reg;
   logic [6:0]              seg_next;
   logic [NUM_DIGITS-1:0]   an_reg;
   logic [NUM_DIGITS-1:0]   an_next;
   logic                    frame_done_reg;

   logic                    tick;
   logic                    wrap;
   logic [NUM_DIGITS-1:0]   digit_sel;
   logic [3:0]              nib [NUM_DIGITS];
   logic [3:0]              cur_nib;

   // Prescaler runs only in SHOW, so each slot is REFRESH_DIV lit cycles
   // followed by the single BLANK cycle.
   tick_gen #(
      .DIV(REFRESH_DIV)
   ) u_tick_gen (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (state_reg == SHOW),
      .tick    (tick)
   );

   // End of the last digit slot: index wraps and the frame completes.
   assign wrap = tick && (idx_reg == IDX_LAST);

   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         assign nib[gi]       = display_reg[4*gi +: 4];
         assign digit_sel[gi] = (idx_reg == IDX_W'(gi));
      end
   endgenerate

   always_comb begin
      cur_nib = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (digit_sel[i]) begin
            cur_nib = nib[i];
         end
      end
   end

   // Mask and blink are applied combinationally here, so a change shows up
   // at the very next output register update rather than at a frame edge.
   always_comb begin
      seg_next = SEG_BLANK;
      an_next  = '1;
      if (state_reg == SHOW && !(|(blank_mask & digit_sel)) &&
          !(blink_en && blink_phase_reg)) begin
         seg_next = hex_to_seg(cur_nib);
         an_next  = ~digit_sel;
      end
   end

   // Scan FSM with its registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= BLANK;
         idx_reg        <= '0;
         seg_reg        <= SEG_BLANK;
         an_reg         <= '1;
         frame_done_reg <= 1'b0;
      end else begin
         seg_reg        <= seg_next;
         an_reg         <= an_next;
         frame_done_reg <= wrap;
         case (state_reg)
            BLANK: state_reg <= SHOW;
            SHOW: begin
               if (tick) begin
                  state_reg <= BLANK;
                  idx_reg   <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
               end
            end
            default: state_reg <= BLANK;
         endcase
      end
   end

   // Double-buffered digit data and blink timing. The display register only
   // changes on the frame wrap; a load landing on that same edge bypasses
   // the shadow so the new value is not delayed a whole frame.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shadow_reg      <= '0;
         display_reg     <= '0;
         pending_reg     <= 1'b0;
         frame_cnt_reg   <= '0;
         blink_phase_reg <= 1'b0;
      end else begin
         if (wrap) begin
            if (load) begin
               shadow_reg  <= digits_in;
               display_reg <= digits_in;
            end else if (pending_reg) begin
               display_reg <= shadow_reg;
            end
            pending_reg <= 1'b0;
            if (frame_cnt_reg == FC_LAST) begin
               frame_cnt_reg   <= '0;
               blink_phase_reg <= ~blink_phase_reg;
            end else begin
               frame_cnt_reg <= frame_cnt_reg + FC_W'(1);
            end
         end else if (load) begin
            shadow_reg  <= digits_in;
            pending_reg <= 1'b1;
         end
      end
   end

   assign seg        = seg_reg;
   assign an         = an_reg;
   assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_driver -- directed bench for seg_scan_driver with
// NUM_DIGITS=2, REFRESH_DIV=4, BLINK_FRAMES=2. Each frame is 10 cycles:
// BLANK, 4 x digit 0, BLANK, 4 x digit 1 (frame_done on the last one).
// Expected per-cycle outputs are queued per frame and popped each cycle.
// ---------------------------------------------------------------------------
module tb_seg_scan_driver;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       load = 1'b0;
   logic [7:0] digits_in = 8'h00;
   logic [1:0] blank_mask = 2'b00;
   logic       blink_en = 1'b0;
   logic [6:0] seg;
   logic [1:0] an;
   logic       frame_done;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int frame_no = 0;

   typedef struct packed {
      logic [1:0] an;
      logic [6:0] seg;
      logic       fd;
   } exp_t;

   exp_t exp_q[$];

   seg_scan_driver #(
      .NUM_DIGITS   (2),
      .REFRESH_DIV  (4),
      .BLINK_FRAMES (2)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (load),
      .digits_in  (digits_in),
      .blank_mask (blank_mask),
      .blink_en   (blink_en),
      .seg        (seg),
      .an         (an),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
      end
   endtask

   // Queue one frame of expected outputs (one transaction = one frame).
   task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                             input logic dark0, input logic dark1);
      for (int j = 1; j <= 10; j++) begin
         exp_t e;
         e.an  = 2'b11;
         e.seg = 7'h7F;
         e.fd  = (j == 10);
         if (j >= 2 && j <= 5 && !dark0) begin
            e.an  = 2'b10;
            e.seg = s0;
         end
         if (j >= 7 && !dark1) begin
            e.an  = 2'b01;
            e.seg = s1;
         end
         exp_q.push_back(e);
      end
      $display("frame %0d: expect d0=%h d1=%h dark=%b%b", frame_no, s0, s1, dark1, dark0);
      frame_no++;
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         exp_t e;
         @(posedge clk);
         #1;
         cyc++;
         if (exp_q.size() == 0) begin
            checks++;
            assert (exp_q.size() != 0)
            else begin
               errors++;
               $error("FAIL queue_empty cyc=%0d observed=0 expected=entry", cyc);
            end
         end else begin
            e = exp_q.pop_front();
            chk("an", {6'd0, an}, {6'd0, e.an});
            chk("seg", {1'b0, seg}, {1'b0, e.seg});
            chk("frame_done", {7'd0, frame_done}, {7'd0, e.fd});
         end
      end
   endtask

   initial begin
      // Reset state while held in reset across clock edges.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_seg", {1'b0, seg}, 8'h7F);
      chk("rst_an", {6'd0, an}, 8'h03);
      chk("rst_fd", {7'd0, frame_done}, 8'h00);
      #4 reset_n = 1'b1;

      // Frame 0: display cleared to zeros.
      push_frame(7'h40, 7'h40, 1'b0, 1'b0);
      run_cycles(10);

      // Frame 1: load mid digit 0 must not tear the current frame.
      push_frame(7'h40, 7'h40, 1'b0, 1'b0);
      run_cycles(2);
      load = 1'b1; digits_in = 8'hA5;
      run_cycles(1);
      load = 1'b0;
      run_cycles(7);

      // Frame 2: new value visible (5, A).
      push_frame(7'h12, 7'h08, 1'b0, 1'b0);
      run_cycles(10);

      // Frame 3: load landing exactly on the wrap edge.
      push_frame(7'h12, 7'h08, 1'b0, 1'b0);
      run_cycles(9);
      load = 1'b1; digits_in = 8'h3C;
      run_cycles(1);
      load = 1'b0;

      // Frame 4: coincident load shows immediately (C, 3).
      push_frame(7'h46, 7'h30, 1'b0, 1'b0);
      run_cycles(2);
      load = 1'b1; digits_in = 8'h11;
      run_cycles(1);
      load = 1'b0;
      run_cycles(2);
      load = 1'b1; digits_in = 8'hF8;
      run_cycles(1);
      load = 1'b0;
      run_cycles(4);

      // Frame 5: last load in the frame wins (8, F).
      push_frame(7'h00, 7'h0E, 1'b0, 1'b0);
      run_cycles(2);
      load = 1'b1; digits_in = 8'h99;
      run_cycles(1);
      load = 1'b0;
      run_cycles(1);

      // Asynchronous reset mid-SHOW, between clock edges.
      #2 reset_n = 1'b0;
      #1;
      chk("arst_seg", {1'b0, seg}, 8'h7F);
      chk("arst_an", {6'd0, an}, 8'h03);
      chk("arst_fd", {7'd0, frame_done}, 8'h00);
      exp_q.delete();
      blink_en = 1'b1;
      #1 reset_n = 1'b1;

      // After reset: zeros, pending 99 discarded, then blink pattern.
      push_frame(7'h40, 7'h40, 1'b0, 1'b0);
      run_cycles(10);
      push_frame(7'h40, 7'h40, 1'b0, 1'b0);
      run_cycles(10);
      for (int f = 2; f < 8; f++) begin
         if ((f / 2) % 2 == 1) push_frame(7'h40, 7'h40, 1'b1, 1'b1);
         else                  push_frame(7'h40, 7'h40, 1'b0, 1'b0);
         run_cycles(10);
      end

      // Frame 8 (lit phase): digit 1 masked.
      blank_mask = 2'b10;
      push_frame(7'h40, 7'h40, 1'b0, 1'b1);
      run_cycles(10);

      // Frame 9: mask cleared during digit 0 takes effect within the frame.
      push_frame(7'h40, 7'h40, 1'b0, 1'b0);
      run_cycles(3);
      blank_mask = 2'b00;
      run_cycles(7);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 48000, clk cycles per digit slot (legal >= 2).
REQ-003 SHALL have parameter BLINK_FRAMES, default 128, full frames per blink half-period (legal >= 1).
REQ-004 SHALL have one clock and an asynchronous, active-low reset; ports in order below.
REQ-005 clk  input  1  system clock (48 MHz HSOSC in current designs).
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 load  input  1  capture digits_in into shadow register on this rising edge.
REQ-008 digits_in  input  4*NUM_DIGITS  hex nibbles; digit i = bits [4i+3:4i].
REQ-009 blank_mask  input  NUM_DIGITS  bit i high keeps digit i dark.
REQ-010 blink_en  input  1  high gates whole display with blink phase.
REQ-011 seg  output  7  active-low segments, {g,f,e,d,c,b,a}.
REQ-012 an  output  NUM_DIGITS  active-low digit enables, at most one low.
REQ-013 frame_done  output  1  one-cycle pulse at end of last digit slot.

Function
REQ-014 Prescaler SHALL count 0..REFRESH_DIV-1, assert tick when count = REFRESH_DIV-1, then wrap to 0.
REQ-015 FSM SHALL have states BLANK and SHOW; BLANK lasts exactly one cycle then goes to SHOW; SHOW goes to BLANK on tick.
REQ-016 Digit index SHALL increment on SHOW->BLANK, wrapping NUM_DIGITS-1 -> 0.
REQ-017 In BLANK, seg SHALL be 7'h7F and an all ones (break-before-make).
REQ-018 In SHOW, an[idx] SHALL be 0 unless blank_mask[idx]=1 or (blink_en=1 and blink phase=1), in which case all an = 1 and seg = 7'h7F.
REQ-019 seg and an SHALL be registered; they reflect state/index one cycle after the controlling edge.
REQ-020 Decode SHALL be full hex 0-F, active-low (e.g. 0 -> 7'h40, 8 -> 7'h00, F -> 7'h0E).
REQ-021 load SHALL write shadow register and set pending; display register SHALL copy shadow only on the wrap of idx to 0 (no mid-frame tearing), clearing pending.
REQ-022 Simultaneous load and wrap: display register SHALL take digits_in directly; pending cleared.
REQ-023 load repeated within a frame: last value wins.
REQ-024 frame_done SHALL pulse on the SHOW->BLANK transition from idx = NUM_DIGITS-1.
REQ-025 Frame counter SHALL count frame_done pulses; at BLINK_FRAMES it wraps to 0 and toggles blink phase; phase runs regardless of blink_en.
REQ-026 blink_en and blank_mask SHALL take effect at the next registered output update, not deferred to frame boundary.

Reset
REQ-027 Assertion of reset_n SHALL immediately force seg = 7'h7F, an all ones, frame_done = 0, independent of clk.
REQ-028 Reset SHALL clear prescaler, idx, frame counter, blink phase, pending, shadow and display registers to 0; FSM to BLANK.
REQ-029 After release, first SHOW SHALL begin on the second rising edge, digit 0.
REQ-030 Reset mid-frame SHALL discard pending load.

Structure
REQ-031 Shared package seg_pkg SHALL hold FSM state enum, SEG_BLANK constant 7'h7F and the hex-to-segment function.
REQ-032 Prescaler SHALL be sub-module tick_gen (parameter DIV, outputs one-cycle tick).
REQ-033 Implementation SHALL be 120-400 lines RTL with elaboration-time checks on parameter ranges.

Verification (bench parameters NUM_DIGITS=2, REFRESH_DIV=4, BLINK_FRAMES=2)
REQ-034 Reset release, digits 0 -> an sequence 11,10(4 cyc),11(1),01(4),11(1),... seg 7'h40 when lit; frame_done every 10 cycles.
REQ-035 load 8'hA5 mid-digit-0 -> digit 1 still shows 0; next frame digit0 = 5 (7'h12), digit1 = A (7'h08).
REQ-036 load coincident with idx wrap with 8'h3C -> that frame shows C then 3, no stale frame.
REQ-037 blink_en=1 -> display dark for frames 2-3, lit 4-5, dark 6-7; blank_mask=2'b10 -> an[1] never low.
REQ-038 reset_n low mid-SHOW between edges -> seg 7'h7F, an 2'b11 same timestep; release restarts at digit 0 with display 0.
